// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Groups the two master request channels and the shared memory bus of the
// two-master round-robin bus arbiter.
//   master modport : requesting side. Drives req/addr/we/sel/wdata for both
//                    masters and data_in from memory. Receives done, rdata
//                    and the bus strobes.
//   slave modport  : arbiter side. This is the mirror image of the master
//                    modport.
// ---------------------------------------------------------------------------
interface bus_arbiter_if;
  // Master 0 is the CPU core. Master 1 is the secondary master.
  logic        m0_req;
  logic        m1_req;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic        m0_we;
  logic        m1_we;
  logic        m0_sel;
  logic        m1_sel;
  logic [7:0]  m0_wdata;
  logic [7:0]  m1_wdata;
  logic        m0_done;
  logic        m1_done;
  logic [7:0]  rdata;
  // Shared memory bus
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        read_en;
  logic        write_en;
  logic        memory_select;
  logic        busy;

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
           m0_sel, m1_sel, m0_wdata, m1_wdata, data_in,
    input  m0_done, m1_done, rdata, addr_bus, data_out,
           read_en, write_en, memory_select, busy
  );

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
           m0_sel, m1_sel, m0_wdata, m1_wdata, data_in,
    output m0_done, m1_done, rdata, addr_bus, data_out,
           read_en, write_en, memory_select, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// This module arbitrates between two masters that share one memory bus. It
// uses round-robin arbitration. Each access passes through the states
// IDLE -> ADDR -> STROBE (ACCESS_CYCLES cycles) -> DONE -> IDLE.
// Every output is taken straight from a flop.
// Ports:
//   clk : single clock. All state changes on the rising edge.
//   rst : asynchronous active-high reset.
//   bus : bus_arbiter_if.slave. It carries the master request channels,
//         the done pulses, rdata and the shared bus strobes.
// Parameters:
//   ACCESS_CYCLES : strobe width in clk cycles. The legal range is 1..15.
//   RESET_SEL     : value of memory_select during and after reset.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic        RESET_SEL     = 1'b1
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_q,  state_d;
  logic        last_q,   last_d;    // master served most recently
  logic        grant_q,  grant_d;   // master owning the current access
  logic        we_q,     we_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [15:0] addr_q,   addr_d;
  logic [7:0]  dout_q,   dout_d;
  logic [7:0]  rdata_q,  rdata_d;
  logic        msel_q,   msel_d;
  logic        rd_q,     rd_d;
  logic        wr_q,     wr_d;
  logic        done0_q,  done0_d;
  logic        done1_q,  done1_d;
  logic        busy_q,   busy_d;
  logic        win_s;

  // Arbitration winner. A tie goes to the master that was not served last.
  // A single request wins outright.
  always_comb begin
    if (bus.m0_req && bus.m1_req) begin
      win_s = ~last_q;
    end else begin
      win_s = bus.m1_req;
    end
  end

  // This block computes the next state and the next value of every output
  // register.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    msel_d  = msel_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Bus values are loaded here so that they are already on the bus
          // during ADDR.
          state_d = ADDR;
          grant_d = win_s;
          if (win_s) begin
            addr_d = bus.m1_addr;
            we_d   = bus.m1_we;
            msel_d = bus.m1_sel;
            dout_d = bus.m1_wdata;
          end else begin
            addr_d = bus.m0_addr;
            we_d   = bus.m0_we;
            msel_d = bus.m0_sel;
            dout_d = bus.m0_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
        rd_d    = ~we_q;
        wr_d    = we_q;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          // This is the last strobe cycle. A read samples data_in here.
          state_d = DONE;
          done0_d = ~grant_q;
          done1_d = grant_q;
          if (!we_q) begin
            rdata_d = bus.data_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // This block holds the state and output registers. Reset clears them
  // asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      msel_q  <= RESET_SEL;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      msel_q  <= msel_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.addr_bus      = addr_q;
  assign bus.data_out      = dout_q;
  assign bus.rdata         = rdata_q;
  assign bus.memory_select = msel_q;
  assign bus.read_en       = rd_q;
  assign bus.write_en      = wr_q;
  assign bus.m0_done       = done0_q;
  assign bus.m1_done       = done1_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. The main instance uses ACCESS_CYCLES 2.
// Two extra instances use ACCESS_CYCLES 1 and 15. They share the main input
// stimulus.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
  localparam int AC = 2;

  typedef struct {
    logic        master;
    logic        we;
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [7:0]  exp_rdata;
  } vec_t;

  typedef struct {
    logic        master;
    logic        we;
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          drive_cyc;
    int          exp_lat;   // 0 = latency not checked
    int          exp_gap;   // 0 = spacing from previous done not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter_if bif();
  bus_arbiter_if bif1();
  bus_arbiter_if bif15();

  bus_arbiter #(.ACCESS_CYCLES(AC), .RESET_SEL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bif));
  bus_arbiter #(.ACCESS_CYCLES(1),  .RESET_SEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bif1));
  bus_arbiter #(.ACCESS_CYCLES(15), .RESET_SEL(1'b1)) dut15 (.clk(clk), .rst(rst), .bus(bif15));

  assign bif1.m0_req    = bif.m0_req;    assign bif15.m0_req    = bif.m0_req;
  assign bif1.m1_req    = bif.m1_req;    assign bif15.m1_req    = bif.m1_req;
  assign bif1.m0_addr   = bif.m0_addr;   assign bif15.m0_addr   = bif.m0_addr;
  assign bif1.m1_addr   = bif.m1_addr;   assign bif15.m1_addr   = bif.m1_addr;
  assign bif1.m0_we     = bif.m0_we;     assign bif15.m0_we     = bif.m0_we;
  assign bif1.m1_we     = bif.m1_we;     assign bif15.m1_we     = bif.m1_we;
  assign bif1.m0_sel    = bif.m0_sel;    assign bif15.m0_sel    = bif.m0_sel;
  assign bif1.m1_sel    = bif.m1_sel;    assign bif15.m1_sel    = bif.m1_sel;
  assign bif1.m0_wdata  = bif.m0_wdata;  assign bif15.m0_wdata  = bif.m0_wdata;
  assign bif1.m1_wdata  = bif.m1_wdata;  assign bif15.m1_wdata  = bif.m1_wdata;
  assign bif1.data_in   = bif.data_in;   assign bif15.data_in   = bif.data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  {31'd0, bif.busy},          32'd0);
    chk({tag, "_rd"},    {31'd0, bif.read_en},       32'd0);
    chk({tag, "_wr"},    {31'd0, bif.write_en},      32'd0);
    chk({tag, "_done"},  {30'd0, bif.m1_done, bif.m0_done}, 32'd0);
    chk({tag, "_addr"},  {16'd0, bif.addr_bus},      32'd0);
    chk({tag, "_dout"},  {24'd0, bif.data_out},      32'd0);
    chk({tag, "_rdata"}, {24'd0, bif.rdata},         32'd0);
    chk({tag, "_msel"},  {31'd0, bif.memory_select}, 32'd1);
  endtask

  task automatic drive(input logic m, input logic req, input logic we, input logic sel,
                       input logic [15:0] a, input logic [7:0] wd);
    if (m) begin
      bif.m1_req = req; bif.m1_we = we; bif.m1_sel = sel; bif.m1_addr = a; bif.m1_wdata = wd;
    end else begin
      bif.m0_req = req; bif.m0_we = we; bif.m0_sel = sel; bif.m0_addr = a; bif.m0_wdata = wd;
    end
  endtask

  task automatic push(input logic m, input logic we, input logic sel, input logic [15:0] a,
                      input logic [7:0] wd, input logic [7:0] rd, input int lat, input int gap);
    exp_t e;
    e.master = m; e.we = we; e.sel = sel; e.addr = a; e.wdata = wd; e.exp_rdata = rd;
    e.drive_cyc = cyc; e.exp_lat = lat; e.exp_gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      step();
      n++;
    end
    if (done_seen < target) chk("done_timeout", done_seen, target);
  endtask

  // Monitor and scoreboard for the main instance. It samples on the falling edge.
  int   strobe_cnt = 0;
  logic saw_rd = 1'b0;
  logic saw_wr = 1'b0;
  int   last_done_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        strobe_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      end else begin
        if (bif.read_en || bif.write_en) begin
          chk("strobe_overlap", {31'd0, bif.read_en & bif.write_en}, 32'd0);
          chk("busy_in_strobe", {31'd0, bif.busy}, 32'd1);
          strobe_cnt++;
          saw_rd = saw_rd | bif.read_en;
          saw_wr = saw_wr | bif.write_en;
        end
        if (bif.m0_done || bif.m1_done) begin
          chk("done_overlap", {31'd0, bif.m0_done & bif.m1_done}, 32'd0);
          if (sb_q.size() == 0) begin
            chk("unexpected_done", {30'd0, bif.m1_done, bif.m0_done}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("done_master", {31'd0, bif.m1_done}, {31'd0, e.master});
            chk("rdata", {24'd0, bif.rdata}, {24'd0, e.exp_rdata});
            chk("addr_bus", {16'd0, bif.addr_bus}, {16'd0, e.addr});
            chk("mem_sel", {31'd0, bif.memory_select}, {31'd0, e.sel});
            chk("strobe_width", strobe_cnt, AC);
            chk("strobe_kind", {30'd0, saw_wr, saw_rd}, e.we ? 32'd2 : 32'd1);
            if (e.we) chk("data_out", {24'd0, bif.data_out}, {24'd0, e.wdata});
            if (e.exp_lat != 0) chk("latency", cyc - e.drive_cyc, e.exp_lat);
            if (e.exp_gap != 0) chk("done_gap", cyc - last_done_cyc, e.exp_gap);
          end
          last_done_cyc = cyc;
          done_seen++;
          strobe_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        end
      end
    end
  end

  vec_t vecs[6];
  int   d1, d15, s1, s15, e0;
  logic [7:0] r1, r15;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'hA845, 8'h00, 8'h3C, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0030, 8'h55, 8'hEE, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h1234, 8'h00, 8'hA5, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h11, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h8001, 8'hAA, 8'h22, 8'hFF};

    rst = 1'b1;
    bif.data_in = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) step();
    chk_reset("por");
    rst = 1'b0;
    step();

    // Single-master accesses from the vector table
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].master, 1'b1, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata);
      bif.data_in = vecs[i].din;
      push(vecs[i].master, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, AC + 2, 0);
      wait_done(done_seen + 1, 20);
      drive(vecs[i].master, 1'b0, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata);
    end

    // Both masters request continuously from reset. The grants alternate, starting with m0.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 8'h02);
    bif.data_in = 8'h77;
    repeat (2) step();
    rst = 1'b0;
    push(1'b0, 1'b0, 1'b1, 16'h1111, 8'h01, 8'h77, AC + 2, 0);
    push(1'b1, 1'b0, 1'b0, 16'h2222, 8'h02, 8'h77, 0, 5);
    push(1'b0, 1'b0, 1'b1, 16'h1111, 8'h01, 8'h77, 0, 5);
    push(1'b1, 1'b0, 1'b0, 16'h2222, 8'h02, 8'h77, 0, 5);
    wait_done(done_seen + 4, 40);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 8'h02);
    step();

    // m1 raises its request while m0 is in STROBE. m1 is served right after m0's DONE and IDLE.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 8'h99);
    push(1'b0, 1'b1, 1'b1, 16'h4000, 8'h99, 8'h77, AC + 2, 0);
    repeat (2) step();
    chk("m0_in_strobe", {31'd0, bif.write_en}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h5000, 8'h00);
    bif.data_in = 8'h42;
    push(1'b1, 1'b0, 1'b1, 16'h5000, 8'h00, 8'h42, 0, 5);
    wait_done(done_seen + 1, 20);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 8'h99);
    wait_done(done_seen + 1, 20);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 8'h00);
    step();

    // Reset in the middle of a STROBE. The access is dropped and no done appears.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h6000, 8'h00);
    bif.data_in = 8'h5A;
    repeat (2) step();
    chk("pre_rst_strobe", {31'd0, bif.read_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    sb_q.delete();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h7000, 8'h00);
    repeat (3) step();
    rst = 1'b0;
    push(1'b0, 1'b0, 1'b1, 16'h7000, 8'h00, 8'h5A, AC + 2, 0);
    push(1'b1, 1'b0, 1'b0, 16'h6000, 8'h00, 8'h5A, 0, 5);
    wait_done(done_seen + 2, 30);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h7000, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h6000, 8'h00);

    // Strobe widths and latencies for ACCESS_CYCLES 1 and 15
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 8'h00);
    bif.data_in = 8'hC3;
    push(1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h00, 8'hC3, AC + 2, 0);
    e0 = cyc; d1 = 0; d15 = 0; s1 = 0; s15 = 0; r1 = 8'h00; r15 = 8'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (d1 == 0) begin
        if (bif1.read_en) s1++;
        if (bif1.m0_done) begin d1 = cyc; r1 = bif1.rdata; end
      end
      if (d15 == 0) begin
        if (bif15.read_en) s15++;
        if (bif15.m0_done) begin d15 = cyc; r15 = bif15.rdata; end
      end
      if (bif.m0_done) bif.m0_req = 1'b0;
    end
    chk("ac1_latency", d1 - e0, 3);
    chk("ac15_latency", d15 - e0, 17);
    chk("ac1_strobe", s1, 1);
    chk("ac15_strobe", s15, 15);
    chk("ac1_rdata", {24'd0, r1}, 32'h0000_00C3);
    chk("ac15_rdata", {24'd0, r15}, 32'h0000_00C3);

    repeat (3) step();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
